// File: rtl/cpu_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester IDs
// and the width of the latency counter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CW = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie is resolved in favour of the requester named by ptr_i.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o    = |req_i;
  assign winner_o = (&req_i) ? ptr_i : req_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-RAM port between the CPU load/store path and the debug
// loader. Handshake: a requester holds req and payload until its one-cycle
// gnt; the matching one-cycle rvalid later marks completion, with rdata valid.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wmask,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_wmask,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic [1:0]      state_o
);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wmask_q, wmask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              pick_any, pick_winner;

  rr_pick2 u_pick (
    .req_i    ({dbg_req, cpu_req}),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= REQ_CPU;
      owner_q <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_winner;
          if (pick_winner == REQ_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            wmask_d = dbg_wmask;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            wmask_d = cpu_wmask;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Stores report zero so the response never carries stale RAM data.
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_gnt    = (state_q == ISSUE) && (owner_q == REQ_CPU);
  assign dbg_gnt    = (state_q == ISSUE) && (owner_q == REQ_DBG);
  assign cpu_rvalid = (state_q == RESP)  && (owner_q == REQ_CPU);
  assign dbg_rvalid = (state_q == RESP)  && (owner_q == REQ_DBG);
  assign mem_en     = (state_q == ISSUE);
  assign mem_we     = (state_q == ISSUE) && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q != IDLE);
  assign state_o    = state_q;

endmodule
